button_event_encoder: RTL

- Consumer end of the button routing path: takes the two 4-bit button banks (A, B) produced by the button mux and converts them into a stream of discrete press events.
- Each line is synchronised, debounced and rising-edge detected. Events are encoded as {bank, index}, queued in a small FIFO and handed to downstream control logic over a valid/ready interface.

---
 rtl/button_event_encoder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/button_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : button_event_encoder
// Description : Turns two 4-bit button banks into a stream of press events.
//               Every line is synchronised (2 flops), debounced with an 8-bit
//               counter and rising-edge detected. A detected press latches a
//               per-line pending bit; a fixed-priority encoder (A0 highest,
//               B3 lowest) writes at most one {bank,index} event per cycle
//               into a first-word-fall-through FIFO read over valid/ready.
//
// Ports       : clock       - system clock, rising edge
//               reset       - asynchronous, active-high reset
//               inA[3:0]    - bank A button lines (lines 0..3), async
//               inB[3:0]    - bank B button lines (lines 4..7), async
//               evt_valid   - FIFO head holds an event
//               evt_ready   - consumer takes the head when evt_valid=1
//               evt_bank    - bank of head event (0=A, 1=B)
//               evt_button  - button index of head event
//               fifo_count  - number of queued events, 0..FIFO_DEPTH
//               overflow    - sticky: a press was merged into a pending one
//
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int DEPTH_LOG2      = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            inA,
    input  logic [3:0]            inB,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic                  evt_bank,
    output logic [1:0]            evt_button,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow
);

    localparam int                    c_NUM_LINES = 8;
    // Counter value on which a still-differing line flips its stable value.
    localparam logic [7:0]            c_DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEPTH_LOG2:0]   c_FIFO_FULL = (DEPTH_LOG2 + 1)'(FIFO_DEPTH);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE   = (DEPTH_LOG2 + 1)'(1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [7:0]            w_lines;
    logic [7:0]            w_stable;
    logic [7:0]            r_stableDly;
    logic [7:0]            w_rise;
    logic [7:0]            r_pending;
    logic [7:0]            w_clear;
    logic [2:0]            w_selIdx;
    logic                  w_anyPending;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [2:0]            r_mem [FIFO_DEPTH];
    logic [2:0]            w_head;
    logic                  r_overflow;

    // Line numbering: bank B occupies the upper four lines.
    assign w_lines = {inB, inA};

    // ------------------------------------------------------------------
    // Per-line synchroniser and debouncer
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < c_NUM_LINES; gi++) begin : g_line
        logic       r_syncMeta;
        logic       r_syncOut;
        logic       r_stable;
        logic [7:0] r_dbCount;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_syncMeta <= 1'b0;
                r_syncOut  <= 1'b0;
                r_stable   <= 1'b0;
                r_dbCount  <= 8'd0;
            end else begin
                r_syncMeta <= w_lines[gi];
                r_syncOut  <= r_syncMeta;
                // The counter measures how long the synchronised line has
                // disagreed with the stable value; any agreement restarts it,
                // so a glitch shorter than DEBOUNCE_CYCLES cannot flip it.
                if (r_syncOut == r_stable) begin
                    r_dbCount <= 8'd0;
                end else if (r_dbCount == c_DB_LAST) begin
                    r_stable  <= ~r_stable;
                    r_dbCount <= 8'd0;
                end else begin
                    r_dbCount <= r_dbCount + 8'd1;
                end
            end
        end

        assign w_stable[gi] = r_stable;
    end

    // ------------------------------------------------------------------
    // Rising-edge detect: a 0->1 stable transition is visible for exactly
    // one cycle and latches the pending bit on the following edge.
    // ------------------------------------------------------------------
    assign w_rise = w_stable & ~r_stableDly;

    // ------------------------------------------------------------------
    // Priority encoder: lowest-numbered pending line wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_selIdx     = 3'd0;
        w_anyPending = 1'b0;
        for (int i = c_NUM_LINES - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_selIdx     = 3'(i);
                w_anyPending = 1'b1;
            end
        end
    end

    assign w_full = (r_count == c_FIFO_FULL);
    assign w_pop  = evt_valid & evt_ready;
    // A full FIFO still accepts the write when its head leaves this cycle.
    assign w_push = w_anyPending & (~w_full | w_pop);

    always_comb begin
        w_clear = 8'd0;
        if (w_push) begin
            w_clear[w_selIdx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pending bits and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stableDly <= 8'd0;
            r_pending   <= 8'd0;
            r_overflow  <= 1'b0;
        end else begin
            r_stableDly <= w_stable;
            // A bit being written to the FIFO this cycle is free to take a
            // new press; only a bit that stays set loses the second press.
            r_pending   <= (r_pending & ~w_clear) | w_rise;
            if (|(w_rise & r_pending & ~w_clear)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_mem[k] <= 3'd0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= w_selIdx;
                r_wrPtr        <= r_wrPtr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry is presented directly from storage; its contents while
    // the FIFO is empty carry no meaning.
    assign w_head     = r_mem[r_rdPtr];
    assign evt_valid  = (r_count != '0);
    assign evt_bank   = w_head[2];
    assign evt_button = w_head[1:0];
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
